// File: rtl/fd_pkg.sv
// fd_pkg: shared face-detector constants, FSM state type and dimension check.
package fd_pkg;
    localparam int unsigned PIX_W_DEF  = 8;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned MAX_W_DEF  = 4095;
    localparam int unsigned MAX_H_DEF  = 4095;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic dims_ok(input logic [31:0] w, h, max_w, max_h);
        return w != 0 && h != 0 && w <= max_w && h <= max_h;
    endfunction
endpackage

// File: rtl/ii_line_buffer.sv
// ii_line_buffer: single-port row memory, combinational read, synchronous write.
// Read returns the old word when written at the same address in the same cycle.
module ii_line_buffer #(
    parameter int DEPTH = 4095,
    parameter int W     = 32,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
endmodule

// File: rtl/integral_image_gen.sv
// integral_image_gen: streams a raster tile in and writes its summed-area image
// to memory at y*width + x, one pixel per cycle with a single output register.
module integral_image_gen
    import fd_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAX_W  = MAX_W_DEF,
    parameter int MAX_H  = MAX_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [11:0]       width,
    input  logic [11:0]       height,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t              state;
    logic [11:0]         x, y, w_l, h_l;
    logic [DATA_W-1:0]   row_sum, rs, up, ii, lb_q;
    logic [ADDR_W-1:0]   addr;
    logic                acc, last_x, last;

    assign pix_ready = state == RUN && (!wr_en || wr_ready);
    assign acc       = pix_valid && pix_ready;
    assign last_x    = x == w_l - 12'd1;
    assign last      = last_x && y == h_l - 12'd1;
    assign rs        = (x == 12'd0 ? '0 : row_sum) + DATA_W'(pix_data);
    // Row 0 ignores the buffer, so leftovers from an earlier frame never leak in.
    assign up        = y == 12'd0 ? '0 : lb_q;
    assign ii        = rs + up;

    ii_line_buffer #(.DEPTH(MAX_W), .W(DATA_W), .AW(12)) u_lbuf (
        .clk   (clk),
        .we    (acc),
        .addr  (x),
        .wdata (ii),
        .rdata (lb_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            w_l     <= '0;
            h_l     <= '0;
            row_sum <= '0;
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (wr_ready) wr_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (dims_ok(32'(width), 32'(height), 32'(MAX_W), 32'(MAX_H))) begin
                        w_l     <= width;
                        h_l     <= height;
                        x       <= '0;
                        y       <= '0;
                        row_sum <= '0;
                        addr    <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else err <= 1'b1;
                end
                RUN: if (acc) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr;
                    wr_data <= ii;
                    addr    <= addr + 1'b1;
                    row_sum <= rs;
                    x       <= last_x ? 12'd0 : x + 12'd1;
                    y       <= last_x ? y + 12'd1 : y;
                    if (last) state <= FLUSH;
                end
                FLUSH: if (!wr_en || wr_ready) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/integral_image_gen.md
Name: integral_image_gen

Overview:
- Upstream stage of each face-detection core.
- Accepts a raster-ordered 8-bit grayscale tile, one pixel per handshake, and computes its summed-area (integral) image: ii(x,y) = sum of all pix(i,j) with i<=x, j<=y.
- Writes each ii value into the core's image memory at address y*width + x. The detector's four-corner box sums then read that memory directly.

Parameters:
- PIX_W, 8, pixel width in bits.
- DATA_W, 32, integral value width; also the width of wr_data.
- MAX_W, 4095, maximum tile width; sets the line-buffer depth.
- MAX_H, 4095, maximum tile height.
- ADDR_W, 32, memory write address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled in IDLE only.
- width  in  12  tile width in pixels; latched on accepted start.
- height  in  12  tile height in pixels; latched on accepted start.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block accepts a pixel this cycle.
- pix_data  in  PIX_W  pixel value, raster order (left to right, then top to bottom).
- wr_en  out  1  memory write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  ADDR_W  write address, y*width + x.
- wr_data  out  DATA_W  ii(x,y).
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse after the last write is accepted.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset values: pix_ready, wr_en, busy, done and err are 0; wr_addr and wr_data are 0; state is IDLE; x, y and row_sum are 0. Line-buffer contents are don't-care.
- States: IDLE -> RUN -> FLUSH -> IDLE.
- IDLE:
  - start with width in [1, MAX_W] and height in [1, MAX_H]: latch width and height, clear x, y and row_sum, go to RUN.
  - start with either dimension 0 or out of range: pulse err next cycle, stay IDLE.
  - start while not in IDLE is ignored.
- RUN:
  - pix_ready = !wr_en || wr_ready (single output holding register).
  - A pixel is accepted on pix_valid && pix_ready.
- Per accepted pixel at (x,y):
  - rs = (x==0 ? 0 : row_sum) + pix.
  - up = (y==0 ? 0 : lbuf[x]).
  - ii = rs + up.
  - Update row_sum <= rs and lbuf[x] <= ii; lbuf is read-before-write at the same address in the same cycle.
  - Register wr_en=1, wr_addr = y*width + x, wr_data = ii.
  - Latency: pixel accepted in cycle N, write presented in cycle N+1.
- The address is kept as a running counter incremented per accepted pixel. No multiplier is used.
- While wr_en && !wr_ready: wr_en, wr_addr and wr_data are held stable and no pixel is accepted.
- wr_en drops after acceptance unless a new pixel is accepted in the same cycle. This gives full throughput of 1 pixel/cycle when wr_ready=1.
- Coordinate advance: x++; at x==width-1, x wraps to 0 and y++. Accepting pixel (width-1, height-1) moves the state to FLUSH.
- FLUSH: pix_ready=0. Once the final write is accepted, pulse done for one cycle and go to IDLE.
- Arithmetic is unsigned, modulo 2^DATA_W. 4095*4095*255 < 2^32, so 32 bits never overflow within limits.
- Stale line-buffer data from a previous or aborted frame never leaks, because y==0 forces up=0.
- Reset mid-frame: return to IDLE at the next edge; any pending write is dropped (wr_en=0).
- pix_valid in IDLE or FLUSH is ignored (pix_ready=0).

Decomposition:
- Shared package fd_pkg: PIX_W, DATA_W and ADDR_W defaults, the state enum {IDLE, RUN, FLUSH}, and MAX_W/MAX_H limits. The detector cores use the same package.
- One sub-module: ii_line_buffer.
  - Single-port, MAX_W x DATA_W.
  - Combinational read plus synchronous write at the same address (read-before-write).
  - Isolated so it can be swapped for a RAM macro.

Test Plan:
- 3x3 all-ones tile, wr_ready=1, pix_valid continuous -> writes addr 0..8 = 1,2,3,2,4,6,3,6,9 on consecutive cycles; done pulses once, 1 cycle after the addr-8 write.
- 2x2 pixels {255,255,255,255} -> 255,510,510,1020. 1x4 column {1,2,3,4} -> 1,3,6,10. 4x1 row {1,2,3,4} -> 1,3,6,10.
- 3x3 ramp pix = x+3y (0..8), wr_ready low for 3 cycles at the write of addr 4 -> wr_addr=4 and wr_data=8 held stable, pix_ready=0 for those cycles; final sequence 0,1,3,3,8,15,9,21,36.
- start with width=0, then with height=4096 -> err pulses once each, busy stays 0, no writes.
- Reset asserted after 5 pixels of a 3x3 frame, then a new 3x3 all-ones frame -> output identical to the first scenario (no stale line-buffer data).
- Two back-to-back 3x3 all-ones frames (start again in the cycle after done) -> both produce the first scenario's values; start asserted during RUN is ignored.
